// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem requests, prefetch FIFO
//
// Owns the program counter, issues sequential reads to a synchronous
// instruction memory (data returns one cycle after the request), and buffers
// returned instructions with their addresses in a DEPTH-entry FIFO drained by
// decode through a valid/ready handshake. A redirect from the datapath
// flushes buffered and in-flight work and restarts fetch at redirect_pc.
//
// Optional feature macro: FETCH_JUMP_PREDECODE_EN
//   When defined, an instruction whose opcode (instr[15:13]) equals
//   JUMP_OPCODE redirects fetch to {3'b000, instr[12:0]} as it is pushed.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   imem_req, imem_addr     read strobe and address to instruction memory
//   imem_rdata              read data, valid one cycle after imem_req
//   if_valid, if_instr,     FIFO head valid, instruction and its address
//   if_pc
//   id_ready                decode accepts the head this cycle
//   redirect, redirect_pc   taken jump/branch and its target
//   halt                    level: stop issuing new requests
//   fifo_count              occupied FIFO entries

module fetch_unit #(
  parameter int unsigned    DEPTH       = 4,
  parameter logic [15:0]    RESET_PC    = 16'h0000,
  parameter logic [2:0]     JUMP_OPCODE = 3'b010
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [15:0]                imem_addr,
  input  logic [15:0]                imem_rdata,
  output logic                       if_valid,
  output logic [15:0]                if_instr,
  output logic [15:0]                if_pc,
  input  logic                       id_ready,
  input  logic                       redirect,
  input  logic [15:0]                redirect_pc,
  input  logic                       halt,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

`ifdef FETCH_JUMP_PREDECODE_EN
  localparam logic PREDECODE_EN = 1'b1;
`else
  localparam logic PREDECODE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [15:0]     inflight_pc_q, inflight_pc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     hold_instr_q, hold_instr_d;
  logic [15:0]     hold_pc_q, hold_pc_d;

  logic [15:0]     instr_mem_q [DEPTH];
  logic [15:0]     pc_mem_q    [DEPTH];

  logic            head_valid;
  logic            pop;
  logic            push;
  logic            redir_ext;
  logic            jump_op;
  logic            jump_hit;
  logic            issue;
  logic [CW:0]     occupancy;

  always_comb begin
    head_valid = (count_q != '0);
    pop        = head_valid && id_ready;
    // Redirects are ignored while the unit is still coming out of reset.
    redir_ext  = redirect && (state_q != S_IDLE);
    // The response of last cycle's request is dropped if a redirect kills it.
    push       = inflight_q && !redir_ext;
    jump_op    = (imem_rdata[15:13] == JUMP_OPCODE);
    // An external redirect in the same cycle wins over a predecoded jump.
    jump_hit   = PREDECODE_EN && push && jump_op;
    // Reserve a slot for every outstanding response so a push never overflows.
    occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue      = (state_q == S_RUN) && !halt && !redir_ext && !jump_hit &&
                 (occupancy < (CW+1)'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (halt)  state_d = S_HALT;
      S_HALT:  if (!halt) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redir_ext) begin
      pc_d = redirect_pc;
    end else if (jump_hit) begin
      pc_d = {3'b000, imem_rdata[12:0]};
    end else if (issue) begin
      pc_d = pc_q + 16'd1;
    end
    if (issue) begin
      inflight_pc_d = pc_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redir_ext) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop};
      count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Track the head being shown so the outputs keep their last value when empty.
  always_comb begin
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (head_valid) begin
      hold_instr_d = instr_mem_q[rd_ptr_q];
      hold_pc_d    = pc_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'h0000;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      hold_instr_q  <= 16'h0000;
      hold_pc_q     <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= 16'h0000;
        pc_mem_q[i]    <= 16'h0000;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign imem_req   = issue;
  assign imem_addr  = pc_q;
  assign if_valid   = head_valid;
  assign if_instr   = head_valid ? instr_mem_q[rd_ptr_q] : hold_instr_q;
  assign if_pc      = head_valid ? pc_mem_q[rd_ptr_q]    : hold_pc_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [2:0]  fifo_count;

  logic        imem_req_b;
  logic [15:0] imem_addr_b;
  logic [15:0] imem_rdata_b;
  logic        if_valid_b;
  logic [15:0] if_instr_b;
  logic [15:0] if_pc_b;
  logic        id_ready_b;
  logic        redirect_b;
  logic [15:0] redirect_pc_b;
  logic        halt_b;
  logic [2:0]  fifo_count_b;

  logic        jump_mode;
  logic [15:0] exp_q [$];
  logic [15:0] last_pop_pc;
  int          pops;
  int          checks;
  int          errors;

  fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000), .JUMP_OPCODE(3'b010)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .fifo_count  (fifo_count)
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(16'hFFFE), .JUMP_OPCODE(3'b010)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req_b),
    .imem_addr   (imem_addr_b),
    .imem_rdata  (imem_rdata_b),
    .if_valid    (if_valid_b),
    .if_instr    (if_instr_b),
    .if_pc       (if_pc_b),
    .id_ready    (id_ready_b),
    .redirect    (redirect_b),
    .redirect_pc (redirect_pc_b),
    .halt        (halt_b),
    .fifo_count  (fifo_count_b)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (jump_mode && a == 16'd2) return 16'h4010;
    return 16'hA000 + a;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata   <= imem_req   ? mem_word(imem_addr)   : 16'hDEAD;
    imem_rdata_b <= imem_req_b ? mem_word(imem_addr_b) : 16'hDEAD;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score any handshake before the edge, return 1 unit after it.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    if (if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed pc %0h expected no delivery", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", {16'h0, if_pc}, {16'h0, e});
        chk("sb_instr", {16'h0, if_instr}, {16'h0, mem_word(e)});
        last_pop_pc = e;
        pops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; pops = 0; last_pop_pc = 16'h0;
    rst_n = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
    id_ready_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = 16'h0; halt_b = 1'b0;
    jump_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_imem_req",   {31'h0, imem_req},  32'h0);
    chk("rst_imem_addr",  {16'h0, imem_addr}, 32'h0);
    chk("rst_if_valid",   {31'h0, if_valid},  32'h0);
    chk("rst_if_instr",   {16'h0, if_instr},  32'h0);
    chk("rst_if_pc",      {16'h0, if_pc},     32'h0);
    chk("rst_fifo_count", {29'h0, fifo_count}, 32'h0);
    chk("rst_b_addr",     {16'h0, imem_addr_b}, 32'hFFFE);

    // Sequential fetch and latency
    for (int i = 0; i < 128; i++) exp_q.push_back(16'(i));
    rst_n = 1'b1;
    tick();
    chk("c1_req",   {31'h0, imem_req}, 32'h1);
    chk("c1_addr",  {16'h0, imem_addr}, 32'h0);
    chk("c1_valid", {31'h0, if_valid}, 32'h0);
    tick();
    chk("c2_valid", {31'h0, if_valid}, 32'h0);
    chk("c2_addr",  {16'h0, imem_addr}, 32'h1);
    tick();
    chk("c3_valid", {31'h0, if_valid}, 32'h1);
    chk("c3_pc",    {16'h0, if_pc}, 32'h0);
    chk("c3_instr", {16'h0, if_instr}, 32'hA000);
    chk("c3_pc_b",  {16'h0, if_pc_b}, 32'hFFFE);
    tick();
    chk("c4_pc",    {16'h0, if_pc}, 32'h1);
    chk("c4_pc_b",  {16'h0, if_pc_b}, 32'hFFFF);
    tick();
    chk("c5_pc",    {16'h0, if_pc}, 32'h2);
    chk("c5_pc_b",  {16'h0, if_pc_b}, 32'h0000);
    tick();
    chk("c6_pc",    {16'h0, if_pc}, 32'h3);
    repeat (4) tick();

    // Back-pressure: fill to DEPTH, head stable, no requests while full
    id_ready = 1'b0;
    repeat (10) tick();
    chk("full_count", {29'h0, fifo_count}, 32'h4);
    chk("full_req",   {31'h0, imem_req}, 32'h0);
    chk("full_valid", {31'h0, if_valid}, 32'h1);
    chk("stall_pc",   {16'h0, if_pc}, {16'h0, exp_q[0]});
    chk("stall_instr",{16'h0, if_instr}, {16'h0, mem_word(exp_q[0])});
    id_ready = 1'b1;
    repeat (8) tick();

    // Redirect with 3 buffered entries and one in flight
    id_ready = 1'b0;
    for (int i = 0; i < 10 && fifo_count != 3'd3; i++) tick();
    chk("pre_redir_count", {29'h0, fifo_count}, 32'h3);
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    chk("redir_req", {31'h0, imem_req}, 32'h0);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(16'(16'h0040 + i));
    tick();
    redirect = 1'b0;
    chk("redir_count", {29'h0, fifo_count}, 32'h0);
    chk("redir_valid", {31'h0, if_valid}, 32'h0);
    id_ready = 1'b1;
    #1;
    chk("redir_first_req",  {31'h0, imem_req}, 32'h1);
    chk("redir_first_addr", {16'h0, imem_addr}, 32'h0040);
    tick();
    tick();
    chk("redir_r3_valid", {31'h0, if_valid}, 32'h1);
    chk("redir_r3_pc",    {16'h0, if_pc}, 32'h0040);
    repeat (6) tick();

    // Halt: no requests, drain, hold last head, resume sequentially
    halt = 1'b1;
    #1;
    chk("halt_req0", {31'h0, imem_req}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_req", {31'h0, imem_req}, 32'h0);
    end
    chk("halt_count", {29'h0, fifo_count}, 32'h0);
    chk("halt_valid", {31'h0, if_valid}, 32'h0);
    chk("halt_hold_pc",    {16'h0, if_pc}, {16'h0, last_pop_pc});
    chk("halt_hold_instr", {16'h0, if_instr}, {16'h0, mem_word(last_pop_pc)});
    halt = 1'b0;
    tick();
    chk("resume_req",  {31'h0, imem_req}, 32'h1);
    chk("resume_addr", {16'h0, imem_addr}, {16'h0, last_pop_pc + 16'd1});
    repeat (8) tick();

    // Mid-operation reset, then jump program
    jump_mode = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mrst_count", {29'h0, fifo_count}, 32'h0);
    chk("mrst_valid", {31'h0, if_valid}, 32'h0);
    chk("mrst_req",   {31'h0, imem_req}, 32'h0);
    chk("mrst_addr",  {16'h0, imem_addr}, 32'h0);
    exp_q.delete();
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2);
`ifdef FETCH_JUMP_PREDECODE_EN
    for (int i = 0; i < 64; i++) exp_q.push_back(16'(16 + i));
`else
    for (int i = 0; i < 64; i++) exp_q.push_back(16'(3 + i));
`endif
    pops = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (14) tick();
    chk("jump_pops", {31'h0, (pops >= 5)}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
